// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: in-flight tags, top-level FSM states, saturating counter helper.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VID,
        TAG_CPU
    } tag_t;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam int STARVE_W = 8;

    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                     input logic [STARVE_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Address walker for the power-up RAM clear; only built when RAM_CLEAR_EN is defined.
// Latency: addr advances one word per enabled cycle. No backpressure: runs whenever en is high.
`ifdef RAM_CLEAR_EN
module ram_clear_seq #(
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (en) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
    assign done = en && (addr_q == {ADDR_W{1'b1}});

endmodule
`endif

// File: rtl/ram_port_arbiter.sv
// Shares one single-port sync RAM between video fetch (default winner) and CPU; RAM_CLEAR_EN adds a power-up clear.
// Latency: 3 edges from issue to vid_valid / cpu_ack, fully pipelined for video, one CPU op in flight.
// Backpressure: CPU holds cpu_req until cpu_ack; video is never stalled but loses a slot when the CPU is starved.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_dout,
    output logic              vid_valid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    state_t               state_q, state_d;
    tag_t                 tag1_q, tag1_d;
    tag_t                 tag2_q, tag2_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0]    ram_address_q, ram_address_d;
    logic [DATA_W-1:0]    ram_data_q, ram_data_d;
    logic                 ram_wren_q, ram_wren_d;
    logic                 vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0]    vid_dout_q, vid_dout_d;
    logic                 cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0]    cpu_dout_q, cpu_dout_d;

    logic [ADDR_W-1:0]    clr_addr;
    logic                 clr_done;
    logic                 run;
    logic                 cpu_pend;
    logic                 cpu_win;

`ifdef RAM_CLEAR_EN
    localparam state_t ST_INIT = ST_CLEAR;
    logic clr_en;

    assign clr_en = (state_q == ST_CLEAR);
    assign busy   = clr_en;

    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clock (clock),
        .reset (reset),
        .en    (clr_en),
        .addr  (clr_addr),
        .done  (clr_done)
    );
`else
    localparam state_t ST_INIT = ST_RUN;

    assign busy     = 1'b0;
    assign clr_addr = '0;
    assign clr_done = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        tag1_d        = TAG_NONE;
        tag2_d        = tag1_q;
        starve_d      = starve_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        vid_valid_d   = 1'b0;
        vid_dout_d    = vid_dout_q;
        cpu_ack_d     = 1'b0;
        cpu_dout_d    = cpu_dout_q;

        // Result stage: ram_q belongs to whichever op sits at the tail of the tag pipe.
        if (tag2_q == TAG_VID) begin
            vid_valid_d = 1'b1;
            vid_dout_d  = ram_q;
        end else if (tag2_q == TAG_CPU) begin
            cpu_ack_d  = 1'b1;
            cpu_dout_d = ram_q;
        end

        run      = (state_q == ST_RUN);
        // A CPU op still in either tag stage blocks the next one until its ack cycle.
        cpu_pend = run && cpu_req && (tag1_q != TAG_CPU) && (tag2_q != TAG_CPU);
        cpu_win  = cpu_pend && (!vid_req || (starve_q == LIMIT));

        if (!run) begin
            ram_address_d = clr_addr;
            ram_data_d    = '0;
            ram_wren_d    = 1'b1;
            if (clr_done) begin
                state_d = ST_RUN;
            end
        end else if (cpu_win) begin
            tag1_d        = TAG_CPU;
            ram_address_d = cpu_addr;
            ram_data_d    = cpu_din;
            ram_wren_d    = cpu_we;
            starve_d      = '0;
        end else if (vid_req) begin
            tag1_d        = TAG_VID;
            ram_address_d = vid_addr;
            if (cpu_pend) begin
                starve_d = sat_inc(starve_q, LIMIT);
            end
        end

        if (!cpu_req || !run) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_INIT;
            tag1_q        <= TAG_NONE;
            tag2_q        <= TAG_NONE;
            starve_q      <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            vid_valid_q   <= 1'b0;
            vid_dout_q    <= '0;
            cpu_ack_q     <= 1'b0;
            cpu_dout_q    <= '0;
        end else begin
            state_q       <= state_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
            starve_q      <= starve_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            vid_valid_q   <= vid_valid_d;
            vid_dout_q    <= vid_dout_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_dout_q    <= cpu_dout_d;
        end
    end

    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign vid_valid   = vid_valid_q;
    assign vid_dout    = vid_dout_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_dout    = cpu_dout_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, transaction-level reference model, directed plus random traffic.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LIMIT  = 15;
`ifdef RAM_CLEAR_EN
    localparam int CLR_WORDS = DEPTH;
`else
    localparam int CLR_WORDS = 0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we, vid_req;
    logic [ADDR_W-1:0] cpu_addr, vid_addr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout, vid_dout, ram_data, ram_q;
    logic              cpu_ack, vid_valid, ram_wren, busy;
    logic [ADDR_W-1:0] ram_address;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_valid(vid_valid),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural single-port RAM: registered q, read-during-write returns the old word.
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    always @(posedge clock) begin
        if (ram_wren) ram[ram_address] <= ram_data;
        ram_q <= ram[ram_address];
    end

    // Reference model state (transaction level).
    logic [DATA_W-1:0] mmem [0:DEPTH-1];
    logic [DATA_W-1:0] exp_vd [int];
    logic [DATA_W-1:0] exp_cd [int];
    int                n = 0;
    int                starve = 0;
    int                cpu_free = 0;
    int                clear_left = 0;
    logic              exp_wr, exp_rst;
    logic [ADDR_W-1:0] exp_wa;
    logic [DATA_W-1:0] exp_wd;

    int tests = 0;
    int fails = 0;
    int vid_cnt = 0, ack_cnt = 0, wr_cnt = 0;
    logic [DATA_W-1:0] last_vid, last_cpu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, expv, n);
        end
    endtask

    // Predict what the arbiter must do at the edge just taken, from the sampled inputs.
    task automatic model_edge();
        logic cpu_pend;
        n++;
        exp_wr  = 1'b0;
        exp_rst = 1'b0;
        if (reset) begin
            exp_vd.delete();
            exp_cd.delete();
            starve     = 0;
            cpu_free   = 0;
            clear_left = CLR_WORDS;
            exp_rst    = 1'b1;
        end else if (clear_left > 0) begin
            exp_wr = 1'b1;
            exp_wa = ADDR_W'(CLR_WORDS - clear_left);
            exp_wd = '0;
            mmem[exp_wa] = '0;
            clear_left--;
            starve = 0;
        end else begin
            cpu_pend = cpu_req && (n >= cpu_free);
            if (cpu_pend && (!vid_req || starve == LIMIT)) begin
                exp_cd[n+2] = mmem[cpu_addr];
                if (cpu_we) begin
                    mmem[cpu_addr] = cpu_din;
                    exp_wr = 1'b1;
                    exp_wa = cpu_addr;
                    exp_wd = cpu_din;
                end
                cpu_free = n + 3;
                starve   = 0;
            end else begin
                if (vid_req) exp_vd[n+2] = mmem[vid_addr];
                if (cpu_pend && vid_req && starve < LIMIT) starve++;
                if (!cpu_req) starve = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("vid_valid", 32'(vid_valid), 32'(exp_vd.exists(n)));
        if (exp_vd.exists(n)) chk("vid_dout", 32'(vid_dout), 32'(exp_vd[n]));
        chk("cpu_ack", 32'(cpu_ack), 32'(exp_cd.exists(n)));
        if (exp_cd.exists(n)) chk("cpu_dout", 32'(cpu_dout), 32'(exp_cd[n]));
        chk("ram_wren", 32'(ram_wren), 32'(exp_wr));
        if (exp_wr) begin
            chk("ram_address", 32'(ram_address), 32'(exp_wa));
            chk("ram_data", 32'(ram_data), 32'(exp_wd));
        end
        chk("busy", 32'(busy), 32'(clear_left > 0));
        if (exp_rst) begin
            chk("rst_ram_address", 32'(ram_address), 32'd0);
            chk("rst_ram_data", 32'(ram_data), 32'd0);
            chk("rst_vid_dout", 32'(vid_dout), 32'd0);
            chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        end
        if (vid_valid === 1'b1) begin vid_cnt++; last_vid = vid_dout; end
        if (cpu_ack === 1'b1) begin ack_cnt++; last_cpu = cpu_dout; end
        if (ram_wren === 1'b1) wr_cnt++;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]  = 8'(i) ^ 8'hA5;
            mmem[i] = 8'(i) ^ 8'hA5;
        end
    endtask

    task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int got = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
        for (int i = 0; i < 30 && got == 0; i++) begin
            step();
            if (cpu_ack === 1'b1) got = 1;
        end
        cpu_req = 1'b0;
        chk("cpu_op_ack_seen", 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles, ack_busy, got, ack_at, v0, w0, a0;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        vid_req = 1'b0; vid_addr = '0;
        preload();
        @(negedge clock);
        repeat (3) step();

        // Power-up: a CPU read pending from the first run cycle must wait out any clear.
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h003;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        ack_busy = 0; got = 0;
        for (int i = 0; i < DEPTH + 20 && got == 0; i++) begin
            step();
            if (busy === 1'b1) busy_cycles++;
            if (cpu_ack === 1'b1) begin got = 1; if (busy === 1'b1) ack_busy++; end
        end
        cpu_req = 1'b0;
        chk("startup_ack_seen", 32'(got), 32'd1);
        chk("startup_ack_while_busy", 32'(ack_busy), 32'd0);
        chk("startup_busy_cycles", 32'(busy_cycles), 32'(CLR_WORDS));
        repeat (2) step();
        preload();

        // Video burst over 0x000..0x00F.
        v0 = vid_cnt;
        for (int i = 0; i < 16; i++) begin
            vid_req = 1'b1; vid_addr = ADDR_W'(i);
            step();
        end
        vid_req = 1'b0;
        repeat (4) step();
        chk("burst_vid_count", 32'(vid_cnt - v0), 32'd16);
        chk("burst_last_data", 32'(last_vid), 32'(8'h0F ^ 8'hA5));

        // CPU alone: write then read back.
        w0 = wr_cnt;
        cpu_op(1'b1, 11'h123, 8'h3C);
        chk("cpu_write_wren_cycles", 32'(wr_cnt - w0), 32'd1);
        chk("cpu_write_old_data", 32'(last_cpu), 32'(8'h23 ^ 8'hA5));
        cpu_op(1'b0, 11'h123, 8'h00);
        chk("cpu_read_back", 32'(last_cpu), 32'h3C);
        repeat (2) step();

        // Contention: video holds the port while a CPU read starves.
        v0 = vid_cnt; a0 = ack_cnt; ack_at = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h055;
        vid_req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            vid_addr = ADDR_W'($urandom_range(0, 255));
            step();
            if (cpu_ack === 1'b1) begin ack_at = i; cpu_req = 1'b0; end
        end
        vid_req = 1'b0;
        repeat (4) step();
        chk("starve_ack_edge", 32'(ack_at), 32'd18);
        chk("starve_ack_count", 32'(ack_cnt - a0), 32'd1);
        chk("starve_vid_count", 32'(vid_cnt - v0), 32'd39);
        chk("starve_cpu_data", 32'(last_cpu), 32'(8'h55 ^ 8'hA5));

        // CPU write followed by a video read of the same word in the next slot.
        v0 = vid_cnt;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h7FF; cpu_din = 8'h5A;
        step();
        vid_req = 1'b1; vid_addr = 11'h7FF;
        step();
        vid_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (cpu_ack === 1'b1) cpu_req = 1'b0;
        end
        cpu_req = 1'b0;
        chk("raw_vid_count", 32'(vid_cnt - v0), 32'd1);
        chk("raw_vid_new_data", 32'(last_vid), 32'h5A);

        // Reset one cycle after a CPU read issues: the op is flushed.
        a0 = ack_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h100;
        step();
        reset = 1'b1; cpu_req = 1'b0;
        step();
        chk("flush_vid_valid", 32'(vid_valid), 32'd0);
        chk("flush_cpu_ack", 32'(cpu_ack), 32'd0);
        reset = 1'b0;
        repeat (6) step();
        chk("flush_no_ack", 32'(ack_cnt - a0), 32'd0);
        for (int i = 0; i < DEPTH + 8 && busy === 1'b1; i++) step();
        chk("flush_busy_done", 32'(busy), 32'd0);
        preload();

        // Random mixed traffic over a small address window to force collisions.
        for (int i = 0; i < 500; i++) begin
            vid_req  = ($urandom_range(0, 7) != 0);
            vid_addr = ADDR_W'($urandom_range(0, 31));
            if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = ADDR_W'($urandom_range(0, 31)); cpu_din = 8'($urandom);
            end
            step();
            if (cpu_ack === 1'b1) begin
                if ($urandom_range(0, 1) == 1) begin
                    cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = ADDR_W'($urandom_range(0, 31)); cpu_din = 8'($urandom);
                end else begin
                    cpu_req = 1'b0;
                end
            end
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
